// File: rtl/adder_settle_driver.sv
// Launches registered operands to an external (slow) adder, waits SETTLE cycles,
// then captures {carry, sum} and holds it until the consumer takes it.
// Optional result self-check: define ADDER_SETTLE_CHECK_EN to add the sticky chk_err output.
module adder_settle_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic             add_co,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_co,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ADDER_SETTLE_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    // The counter is loaded with SETTLE-1 so capture lands exactly SETTLE edges after launch.
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [7:0]         cnt_r;
    logic [7:0]         cnt_nxt_s;
    logic               accept_s;
    logic               capture_s;
    logic               ready_r;
    logic [WIDTH-1:0]   add_a_r;
    logic [WIDTH-1:0]   add_b_r;
    logic               add_ci_r;
    logic               out_co_r;
    logic [WIDTH-1:0]   out_sum_r;
    logic               out_valid_r;

`ifdef ADDER_SETTLE_CHECK_EN
    logic               chk_err_r;
    logic               chk_mismatch_s;

    function automatic logic [WIDTH:0] ref_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci
    );
        ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction
`endif

    // Next-state, counter update and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = SETTLE_M1;
                    state_nxt_s = WAIT;
                end else begin
                    cnt_nxt_s   = 8'd0;
                end
            end
            WAIT: begin
                if (cnt_r == 8'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // State, counter and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
        end
    end

    // Operand launch registers; only an accepted set may change them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a_r  <= {WIDTH{1'b0}};
            add_b_r  <= {WIDTH{1'b0}};
            add_ci_r <= 1'b0;
        end else if (accept_s) begin
            add_a_r  <= in_a;
            add_b_r  <= in_b;
            add_ci_r <= in_ci;
        end else begin
            add_a_r  <= add_a_r;
            add_b_r  <= add_b_r;
            add_ci_r <= add_ci_r;
        end
    end

    // Result capture; the adder's bits are taken verbatim
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_co_r    <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (capture_s) begin
                out_co_r  <= add_co;
                out_sum_r <= add_sum;
            end else begin
                out_co_r  <= out_co_r;
                out_sum_r <= out_sum_r;
            end
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

`ifdef ADDER_SETTLE_CHECK_EN
    assign chk_mismatch_s = ({add_co, add_sum} != ref_sum(add_a_r, add_b_r, add_ci_r));

    // Sticky self-check flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err_r <= 1'b0;
        end else if (capture_s && chk_mismatch_s) begin
            chk_err_r <= 1'b1;
        end else begin
            chk_err_r <= chk_err_r;
        end
    end

    assign chk_err = chk_err_r;
`endif

    assign in_ready  = ready_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_ci    = add_ci_r;
    assign out_co    = out_co_r;
    assign out_sum   = out_sum_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_adder_settle_driver.sv
// Directed bench for adder_settle_driver: one SETTLE=12 instance and one SETTLE=1 instance,
// each driving a behavioural adder model.
module tb_adder_settle_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // dut0: SETTLE=12
    logic       rst0 = 1'b1, iv0 = 1'b0, ci0 = 1'b0, ordy0 = 1'b0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0;
    logic       ir0, aci0, aco0, oco0, ov0;
    logic [3:0] aa0, ab0, asum0, osum0;
    logic       fault0 = 1'b0;
    // dut1: SETTLE=1
    logic       rst1 = 1'b1, iv1 = 1'b0, ci1 = 1'b0, ordy1 = 1'b1;
    logic [3:0] a1 = 4'd0, b1 = 4'd0;
    logic       ir1, aci1, aco1, oco1, ov1;
    logic [3:0] aa1, ab1, asum1, osum1;
`ifdef ADDER_SETTLE_CHECK_EN
    logic       chk0, chk1;
`endif

    // Behavioural adders; dut0's can be made to return a wrong sum for 2+2
    assign {aco0, asum0} = {1'b0, aa0} + {1'b0, ab0} + {4'd0, aci0}
                         + ((fault0 && aa0 == 4'd2 && ab0 == 4'd2) ? 5'd1 : 5'd0);
    assign {aco1, asum1} = {1'b0, aa1} + {1'b0, ab1} + {4'd0, aci1};

    adder_settle_driver #(.WIDTH(4), .SETTLE(12)) u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0),
        .in_a(a0), .in_b(b0), .in_ci(ci0),
        .add_a(aa0), .add_b(ab0), .add_ci(aci0), .add_co(aco0), .add_sum(asum0),
        .out_co(oco0), .out_sum(osum0), .out_valid(ov0), .out_ready(ordy0)
`ifdef ADDER_SETTLE_CHECK_EN
        , .chk_err(chk0)
`endif
    );

    adder_settle_driver #(.WIDTH(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_ci(ci1),
        .add_a(aa1), .add_b(ab1), .add_ci(aci1), .add_co(aco1), .add_sum(asum1),
        .out_co(oco1), .out_sum(osum1), .out_valid(ov1), .out_ready(ordy1)
`ifdef ADDER_SETTLE_CHECK_EN
        , .chk_err(chk1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operand set on dut0 and follow it to capture, checking every cycle
    task automatic run_op0(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic ci, input logic [4:0] exp);
        int n;
        n = 0;
        while (ir0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_ready"}, ir0, 32'd1);
        a0 = a; b0 = b; ci0 = ci; iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        check_eq({tag, "_accept"}, {ir0, ov0, aa0, ab0, aci0}, {1'b0, 1'b0, a, b, ci});
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) begin
                a0 = ~a; b0 = ~b; iv0 = 1'b1;
            end
            tick();
            check_eq($sformatf("%s_wait%0d", tag, k), {ir0, ov0, aa0, ab0, aci0},
                     {1'b0, (k == 12), a, b, ci});
        end
        iv0 = 1'b0;
        check_eq({tag, "_sum"}, {oco0, osum0}, exp);
    endtask

    task automatic handshake0(input string tag);
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        check_eq({tag, "_hs"}, {ov0, ir0}, {1'b0, 1'b1});
    endtask

    initial begin
        logic [4:0] held;
        logic [3:0] ha;
        logic       seen;
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic       vc [4];
        logic [4:0] ve [4];
        va = '{4'h1, 4'h7, 4'hF, 4'h5};
        vb = '{4'h2, 4'h9, 4'h1, 4'h5};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1};
        ve = '{5'h03, 5'h11, 5'h10, 5'h0B};

        // Reset values while reset is held
        tick();
        tick();
        check_eq("rst_outs0", {aa0, ab0, aci0, oco0, osum0, ov0}, 32'd0);
        check_eq("rst_outs1", {aa1, ab1, aci1, oco1, osum1, ov1}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();
        check_eq("rel_ready", {ir0, ir1}, {1'b1, 1'b1});
`ifdef ADDER_SETTLE_CHECK_EN
        check_eq("rst_chk", {chk0, chk1}, 32'd0);
`endif

        run_op0("op34", 4'h3, 4'h4, 1'b0, 5'h07);
        handshake0("op34");
        run_op0("opFF", 4'hF, 4'hF, 1'b1, 5'h1F);
        handshake0("opFF");
        run_op0("op88", 4'h8, 4'h8, 1'b0, 5'h10);

        // Consumer stalls five cycles while inputs toggle
        held = {oco0, osum0};
        ha = aa0;
        for (int k = 0; k < 5; k++) begin
            a0 = 4'(k); b0 = 4'(k + 3); ci0 = k[0]; iv0 = 1'b1;
            tick();
            check_eq($sformatf("hold%0d", k), {ir0, ov0, oco0, osum0, aa0},
                     {1'b0, 1'b1, held, ha});
        end
        // Handshake with in_valid already high: no accept on the handshake edge
        a0 = 4'h9; b0 = 4'h5; ci0 = 1'b0; iv0 = 1'b1;
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        check_eq("nobypass", {ov0, ir0, aa0}, {1'b0, 1'b1, ha});
        tick();
        iv0 = 1'b0;
        check_eq("accept_after_hs", {ir0, aa0, ab0}, {1'b0, 4'h9, 4'h5});
`ifdef ADDER_SETTLE_CHECK_EN
        check_eq("chk_clean", chk0, 32'd0);
`endif

        // Reset at edge N+6 of an operation
        for (int k = 1; k <= 6; k++) tick();
        check_eq("pre_rst", {ov0, ir0, aa0}, {1'b0, 1'b0, 4'h9});
        rst0 = 1'b1;
        #1;
        check_eq("mid_rst_outs", {aa0, ab0, aci0, oco0, osum0, ov0}, 32'd0);
        tick();
        rst0 = 1'b0;
        tick();
        check_eq("post_rst_ready", ir0, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ov0 !== 1'b0) seen = 1'b1;
        end
        check_eq("post_rst_noresult", seen, 32'd0);

`ifdef ADDER_SETTLE_CHECK_EN
        fault0 = 1'b1;
        run_op0("bad22", 4'h2, 4'h2, 1'b0, 5'h05);
        tick();
        check_eq("chk_set", chk0, 32'd1);
        handshake0("bad22");
        fault0 = 1'b0;
        run_op0("ok11", 4'h1, 4'h1, 1'b0, 5'h02);
        tick();
        check_eq("chk_sticky", chk0, 32'd1);
        handshake0("ok11");
        rst0 = 1'b1;
        #1;
        check_eq("chk_rst", chk0, 32'd0);
        tick();
        rst0 = 1'b0;
        tick();
`endif

        // SETTLE=1 back-to-back: one result every three cycles
        check_eq("b2b_ready", ir1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            a1 = va[i]; b1 = vb[i]; ci1 = vc[i]; iv1 = 1'b1;
            tick();
            check_eq($sformatf("b2b_acc%0d", i), {ir1, ov1, aa1, ab1, aci1},
                     {1'b0, 1'b0, va[i], vb[i], vc[i]});
            tick();
            check_eq($sformatf("b2b_res%0d", i), {ov1, oco1, osum1}, {1'b1, ve[i]});
            a1 = ~va[i]; b1 = 4'h0;
            tick();
            check_eq($sformatf("b2b_hs%0d", i), {ov1, ir1, aa1}, {1'b0, 1'b1, va[i]});
        end
        iv1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_settle_driver.md
ADDER_SETTLE_DRIVER -- requirements
Module: adder_settle_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand width in bits.
REQ-002 The block SHALL have parameter SETTLE, default 12: clock cycles from operand launch to result capture; legal range 1..255.
REQ-003 Port clk  input  1: the single clock; all state on rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port in_valid  input  1: upstream offers an operand set.
REQ-006 Port in_ready  output  1: block accepts an operand set this cycle.
REQ-007 Port in_a, in_b  input  WIDTH each: operands; port in_ci  input  1: carry-in.
REQ-008 Ports add_a, add_b  output  WIDTH, add_ci  output  1: registered operands driven to the downstream combinational/delayed adder.
REQ-009 Ports add_co  input  1, add_sum  input  WIDTH: adder result returned to the block.
REQ-010 Ports out_co  output  1, out_sum  output  WIDTH: captured result.
REQ-011 Port out_valid  output  1: captured result available; port out_ready  input  1: consumer takes it.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on in_valid&in_ready at edge N, the block SHALL register in_a/in_b/in_ci onto add_a/add_b/add_ci, load an 8-bit counter with SETTLE-1, and enter WAIT.
REQ-014 WAIT: the counter SHALL decrement each cycle; at the edge where the counter is 0 (edge N+SETTLE), the block SHALL capture add_co/add_sum into out_co/out_sum, set out_valid, and enter HOLD.
REQ-015 With SETTLE=1 the capture SHALL occur at edge N+1 (WAIT lasts one cycle).
REQ-016 add_a/add_b/add_ci SHALL remain stable from edge N until the next accepted operand set; in_* changes outside IDLE SHALL be ignored.
REQ-017 HOLD: out_valid SHALL stay 1 and out_co/out_sum stable until out_ready=1; on that edge out_valid SHALL clear and the FSM SHALL enter IDLE.
REQ-018 There SHALL be no IDLE bypass: a new operand set is accepted no earlier than the cycle after the out handshake; throughput is one result per SETTLE+2 cycles minimum.
REQ-019 out_ready while out_valid=0 SHALL have no effect.
REQ-020 The captured result SHALL be exactly the WIDTH+1 bits {add_co, add_sum}; the block SHALL perform no arithmetic on it.

Reset
REQ-021 rst=1 SHALL immediately force FSM to IDLE, counter to 0, add_a/add_b/add_ci/out_co/out_sum to 0, out_valid to 0.
REQ-022 Reset asserted in WAIT or HOLD SHALL abandon the operation; no result SHALL be presented after release.
REQ-023 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-024 Macro ADDER_SETTLE_CHECK_EN SHALL control a result self-check.
REQ-025 With ADDER_SETTLE_CHECK_EN defined: an output port chk_err (1 bit) SHALL exist; at capture the block SHALL compare {add_co, add_sum} against add_a+add_b+add_ci computed at WIDTH+1 bits and set chk_err sticky on mismatch; only rst clears it.
REQ-026 Without ADDER_SETTLE_CHECK_EN: chk_err port and comparison logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 SETTLE=12, a=4'h3, b=4'h4, ci=0 accepted at edge N -> out_valid rises at edge N+12, {out_co,out_sum}=5'h07; in_ready=0 edges N..N+12.
REQ-028 a=4'hF, b=4'hF, ci=1 -> {out_co,out_sum}=5'h1F; a=4'h8, b=4'h8, ci=0 -> 5'h10 (carry wrap).
REQ-029 out_ready held 0 for 5 cycles after capture -> out_valid and out_sum stable all 5 cycles; in_* toggling meanwhile ignored; next accept one cycle after handshake.
REQ-030 rst pulsed at edge N+6 of a SETTLE=12 operation -> all outputs 0 immediately, no out_valid afterwards, in_ready=1 after release.
REQ-031 SETTLE=1, back-to-back in_valid with out_ready=1 -> one result every 3 cycles, values match operands in order.
REQ-032 With ADDER_SETTLE_CHECK_EN, adder model returns sum off by one for a=2, b=2 -> chk_err=1 and stays 1 through later correct results until rst.
